register_file_bank: RTL and testbench
=====================================

Name: register_file_bank

Overview:
- 32-entry general-purpose register array for the MIPS datapath.
- Sits directly downstream of the write-register decoder and consumes its 32-bit one-hot select vector as per-register write enables.
- Provides two asynchronous read ports to the decode stage and one synchronous write port from write-back.
- Hardwires $zero and flags malformed select vectors.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- SP_RESET, 32'h7FFF_EFFC, reset value of register 29 ($sp).
- GP_RESET, 32'h1000_8000, reset value of register 28 ($gp).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- RegWrite  input  1  write strobe from write-back control.
- SelectRegister  input  32  one-hot write select from the decoder; bit n selects register n.
- WriteData  input  DATA_WIDTH  data to write.
- ReadRegister1  input  5  read address, port 1 (rs).
- ReadRegister2  input  5  read address, port 2 (rt).
- ReadData1  output  DATA_WIDTH  contents of ReadRegister1.
- ReadData2  output  DATA_WIDTH  contents of ReadRegister2.
- SelectError  output  1  sticky flag for a malformed select vector.

Behaviour:
- Reset (reset==0, asynchronous, takes effect immediately, including mid-write):
  - all registers clear to 0, except reg 28 = GP_RESET and reg 29 = SP_RESET;
  - SelectError = 0;
  - ReadData1/2 reflect the reset contents combinationally.
- Write: on posedge clk with reset==1, RegWrite==1, and SelectRegister exactly one-hot, the selected register loads WriteData.
  - Register n is visible on the read ports from the cycle after the edge; latency is 1 clock.
- Register 0:
  - SelectRegister==32'h1 with RegWrite is a legal no-op;
  - reg 0 always reads 0 and never sets SelectError.
- Malformed select (RegWrite==1 with SelectRegister==0 or more than one bit set):
  - no register changes;
  - SelectError is set to 1 at that clock edge and holds until reset.
  - A valid write in the same or a later cycle is unaffected once the select is one-hot again.
- RegWrite==0: SelectRegister is ignored entirely, with no write and no error.
- Reads: purely combinational muxes from the register array; no handshake.
  - Both ports may address the same register.
  - Read address 0 returns 0.
- Simultaneous read and write of the same register (feature disabled): the read returns the old value during that cycle and the new value after the edge.
- No wrap-around or arithmetic; data passes through unmodified at DATA_WIDTH.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - when RegWrite==1, SelectRegister is valid one-hot, and ReadRegisterX equals the selected index (not 0), ReadDataX returns WriteData in the same cycle (write-through bypass);
  - a malformed select never bypasses.
- Undefined: reads always return stored array contents, as in Behaviour.

Decomposition:
- Shared package regfile_pkg:
  - NUM_REGS=32, REG_ADDR_W=5;
  - index constants REG_ZERO=0, REG_GP=28, REG_SP=29;
  - typedef reg_word_t (DATA_WIDTH logic vector);
  - function is_onehot32.
- Sub-module register_cell: one DATA_WIDTH register with enable, asynchronous active-low reset, and a RESET_VALUE parameter.
  - Instantiated 31 times (regs 1..31) via generate.
  - Reg 0 is a constant.

Test Plan:
- Reset release: read regs 0, 5, 28, 29 -> 0, 0, 32'h1000_8000, 32'h7FFF_EFFC; SelectError=0.
- Write 32'hDEADBEEF with SelectRegister=32'h0000_0200 (reg 9), RegWrite=1 -> next cycle ReadRegister1=9 gives 32'hDEADBEEF; all other registers unchanged.
- Write 32'hFFFF_FFFF with SelectRegister=32'h1 -> reg 0 still reads 0; SelectError=0.
- RegWrite=1, SelectRegister=32'h0000_0006 -> regs 1 and 2 unchanged; SelectError=1, stays 1 through subsequent valid writes until reset pulse.
- Same-cycle write reg 7=32'h1234 with ReadRegister2=7 -> ReadData2 shows old value 0 without REGFILE_WRITE_BYPASS_EN and 32'h1234 with it; both show 32'h1234 next cycle.
- Assert reset low mid-write (between edges with RegWrite=1 targeting reg 29) -> reg 29 = SP_RESET immediately; no write occurs at the following edge while reset is low.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, register indices and select-vector helper for register_file_bank
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WORD_W = 32;
  localparam int REG_ZERO = 0;
  localparam int REG_GP = 28;
  localparam int REG_SP = 29;
  typedef logic [WORD_W-1:0] reg_word_t;
  function automatic logic is_onehot32(input logic [31:0] v);
    return (v != 32'h0) && ((v & (v - 32'h1)) == 32'h0);
  endfunction
endpackage

// File: rtl/register_cell.sv
// register_cell: one enabled register with asynchronous active-low reset to RESET_VALUE
module register_cell #(
  parameter int W = 32,
  parameter logic [W-1:0] RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= RESET_VALUE;
    else if (en) q <= d;
endmodule

// File: rtl/register_file_bank.sv
// register_file_bank: 32x DATA_WIDTH MIPS register file, one-hot write select, sticky select error
// Optional same-cycle write-through bypass on the read ports under REGFILE_WRITE_BYPASS_EN.
module register_file_bank
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] SP_RESET = 32'h7FFF_EFFC,
  parameter logic [DATA_WIDTH-1:0] GP_RESET = 32'h1000_8000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [31:0]           SelectRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [4:0]            ReadRegister1,
  input  logic [4:0]            ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic                  SelectError
);
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic valid;
  assign valid = RegWrite && is_onehot32(SelectRegister);
  assign regs[0] = '0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cell
    register_cell #(
      .W(DATA_WIDTH),
      .RESET_VALUE(i == REG_SP ? SP_RESET : i == REG_GP ? GP_RESET : '0)
    ) u_cell (
      .clk(clk),
      .reset(reset),
      .en(valid && SelectRegister[i]),
      .d(WriteData),
      .q(regs[i])
    );
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) SelectError <= 1'b0;
    else if (RegWrite && !is_onehot32(SelectRegister)) SelectError <= 1'b1;
`ifdef REGFILE_WRITE_BYPASS_EN
  // a one-hot select makes SelectRegister[addr] an exact index match
  logic hit1, hit2;
  assign hit1 = valid && ReadRegister1 != REG_ADDR_W'(REG_ZERO) && SelectRegister[ReadRegister1];
  assign hit2 = valid && ReadRegister2 != REG_ADDR_W'(REG_ZERO) && SelectRegister[ReadRegister2];
  assign ReadData1 = hit1 ? WriteData : regs[ReadRegister1];
  assign ReadData2 = hit2 ? WriteData : regs[ReadRegister2];
`else
  assign ReadData1 = regs[ReadRegister1];
  assign ReadData2 = regs[ReadRegister2];
`endif
endmodule

// File: tb/tb_register_file_bank.sv
// tb_register_file_bank: directed scoreboard bench for register_file_bank
module tb_register_file_bank;
  import regfile_pkg::*;
  localparam logic [31:0] SP = 32'h7FFF_EFFC;
  localparam logic [31:0] GP = 32'h1000_8000;
  logic clk = 1'b0;
  logic reset;
  logic RegWrite;
  logic [31:0] SelectRegister;
  reg_word_t WriteData;
  logic [4:0] ReadRegister1, ReadRegister2;
  reg_word_t ReadData1, ReadData2;
  logic SelectError;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string tag;
    int port;
    logic [31:0] exp;
  } item_t;
  item_t q[$];
  register_file_bank dut (
    .clk(clk),
    .reset(reset),
    .RegWrite(RegWrite),
    .SelectRegister(SelectRegister),
    .WriteData(WriteData),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2),
    .SelectError(SelectError)
  );
  always #5 clk = ~clk;
  task automatic push(input string tag, input int port, input logic [31:0] exp);
    item_t it;
    it.tag = tag;
    it.port = port;
    it.exp = exp;
    q.push_back(it);
  endtask
  task automatic drain();
    while (q.size() > 0) begin
      item_t it;
      logic [31:0] got;
      it = q.pop_front();
      got = it.port == 0 ? ReadData1 : it.port == 1 ? ReadData2 : {31'b0, SelectError};
      checks++;
      assert (got === it.exp)
      else begin
        errors++;
        $error("FAIL %s got %h exp %h", it.tag, got, it.exp);
      end
    end
  endtask
  task automatic chk(input string tag, input logic [4:0] a1, input logic [31:0] e1,
                     input logic [4:0] a2, input logic [31:0] e2);
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    push({tag, "_rd1"}, 0, e1);
    push({tag, "_rd2"}, 1, e2);
    #1 drain();
  endtask
  task automatic chk_err(input string tag, input logic e);
    push(tag, 2, {31'b0, e});
    #1 drain();
  endtask
  task automatic wr(input logic [31:0] sel, input logic [31:0] data);
    @(negedge clk);
    RegWrite = 1'b1;
    SelectRegister = sel;
    WriteData = data;
    @(negedge clk);
    RegWrite = 1'b0;
    SelectRegister = 32'h0;
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    reset = 1'b0;
    RegWrite = 1'b0;
    SelectRegister = 32'h0;
    WriteData = '0;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("rst_0_5", 5'd0, 32'h0, 5'd5, 32'h0);
    chk("rst_gp_sp", 5'd28, GP, 5'd29, SP);
    chk_err("rst_err", 1'b0);
    wr(32'h0000_0200, 32'hDEAD_BEEF);
    chk("wr9", 5'd9, 32'hDEAD_BEEF, 5'd8, 32'h0);
    chk("wr9_other", 5'd10, 32'h0, 5'd29, SP);
    wr(32'h1, 32'hFFFF_FFFF);
    chk("wr0", 5'd0, 32'h0, 5'd0, 32'h0);
    chk_err("wr0_err", 1'b0);
    wr(32'h2, 32'h11);
    wr(32'h4, 32'h22);
    chk("wr1_2", 5'd1, 32'h11, 5'd2, 32'h22);
    @(negedge clk);
    SelectRegister = 32'h6;
    WriteData = 32'hBAD;
    @(negedge clk);
    chk("nowr_ignored", 5'd1, 32'h11, 5'd2, 32'h22);
    chk_err("nowr_err", 1'b0);
    wr(32'h6, 32'hBAD);
    chk("multi_hold", 5'd1, 32'h11, 5'd2, 32'h22);
    chk_err("multi_err", 1'b1);
    wr(32'h8, 32'h33);
    chk("after_err_wr3", 5'd3, 32'h33, 5'd9, 32'hDEAD_BEEF);
    chk_err("err_sticky", 1'b1);
    pulse_reset();
    chk_err("err_cleared", 1'b0);
    chk("rst_clears", 5'd9, 32'h0, 5'd3, 32'h0);
    wr(32'h0, 32'h55);
    chk_err("zero_sel_err", 1'b1);
    chk("zero_sel_hold", 5'd0, 32'h0, 5'd28, GP);
    @(negedge clk);
    RegWrite = 1'b1;
    SelectRegister = 32'h80;
    WriteData = 32'h1234;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd7;
`ifdef REGFILE_WRITE_BYPASS_EN
    push("same_cycle_rd2", 1, 32'h1234);
`else
    push("same_cycle_rd2", 1, 32'h0);
`endif
    #1 drain();
    @(negedge clk);
    RegWrite = 1'b0;
    SelectRegister = 32'h0;
    chk("after_edge7", 5'd7, 32'h1234, 5'd7, 32'h1234);
    wr(32'h2000_0000, 32'hAAAA);
    chk("wr29", 5'd29, 32'hAAAA, 5'd7, 32'h1234);
    @(negedge clk);
    RegWrite = 1'b1;
    SelectRegister = 32'h2000_0000;
    WriteData = 32'h5555;
    #2 reset = 1'b0;
    chk("mid_rst", 5'd29, SP, 5'd7, 32'h0);
    @(negedge clk);
    chk("rst_blocks_wr", 5'd29, SP, 5'd28, GP);
    RegWrite = 1'b0;
    SelectRegister = 32'h0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst", 5'd29, SP, 5'd0, 32'h0);
    chk_err("post_rst_err", 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
